final_soc_nios2_qsys_0_oci_dct_packer: RTL and testbench

//  Writer side of the OCI direct-control-trace (DCT) path. Packs 2-bit DCT symbols into
//  dct_buffer[29:0]/dct_count[3:0] and emits full or flushed buffers as 36-bit frames

---
 rtl/final_soc_nios2_qsys_0_oci_pkg.sv | 24 ++
 rtl/final_soc_nios2_qsys_0_oci_dct_packer_if.sv | 11 +
 rtl/final_soc_nios2_qsys_0_oci_dct_frame_reg.sv | 40 ++++
 rtl/final_soc_nios2_qsys_0_oci_dct_packer.sv | 128 ++++++++++++
 tb/tb_final_soc_nios2_qsys_0_oci_dct_packer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/final_soc_nios2_qsys_0_oci_pkg.sv
// Shared OCI trace constants and types for the DCT writer path.
package final_soc_nios2_qsys_0_oci_pkg;

  localparam int unsigned DCT_SYM_W  = 2;
  localparam int unsigned DCT_DEPTH  = 15;
  localparam int unsigned DCT_BUF_W  = DCT_SYM_W * DCT_DEPTH;
  localparam int unsigned DCT_CNT_W  = 4;
  localparam int unsigned DCT_DROP_W = 8;
  localparam int unsigned FRAME_W    = 36;
  localparam logic [1:0]  TAG_DCT    = 2'b10;

  typedef struct packed {
    logic [1:0]           tag;
    logic [DCT_CNT_W-1:0] cnt;
    logic [DCT_BUF_W-1:0] buff;
  } dct_frame_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_FULL  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/final_soc_nios2_qsys_0_oci_dct_packer_if.sv
// Valid/ready frame port from the DCT packer to the OCI trace FIFO.
interface final_soc_nios2_qsys_0_oci_dct_packer_if;
  import final_soc_nios2_qsys_0_oci_pkg::*;

  logic               frame_valid;
  logic               frame_ready;
  logic [FRAME_W-1:0] frame_data;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/final_soc_nios2_qsys_0_oci_dct_frame_reg.sv
// Single-entry valid/ready output register; a load may coincide with a handshake.
module final_soc_nios2_qsys_0_oci_dct_frame_reg
  import final_soc_nios2_qsys_0_oci_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  dct_frame_t load_data,
  input  logic       ready,
  output logic       valid,
  output dct_frame_t data
);

  logic       valid_q, valid_d;
  dct_frame_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (ready) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/final_soc_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit DCT symbols into a 15-deep buffer and emits full or flushed frames.
module final_soc_nios2_qsys_0_oci_dct_packer
  import final_soc_nios2_qsys_0_oci_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  trc_on,
  input  logic                  sym_valid,
  input  logic [DCT_SYM_W-1:0]  sym,
  input  logic                  flush,
  output logic [DCT_BUF_W-1:0]  dct_buffer,
  output logic [DCT_CNT_W-1:0]  dct_count,
  final_soc_nios2_qsys_0_oci_dct_packer_if.master fr,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic [DCT_DROP_W-1:0] drop_cnt
);

  dct_state_e            state_q, state_d;
  logic [DCT_BUF_W-1:0]  buf_q, buf_d, next_buf;
  logic [DCT_CNT_W-1:0]  cnt_q, cnt_d, next_cnt;
  logic                  flush_pend_q, flush_pend_d;
  logic                  trc_on_q;
  logic                  overflow_q, overflow_d;
  logic [DCT_DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       full, acc, drop, fall, fl_req, nonempty, full_next, er, slot_free, load;
  logic       frame_valid;
  dct_frame_t frame_next, frame_out;

  // Output decode from the registered state.
  always_comb begin
    full = (state_q == ST_FULL);
    acc  = sym_valid & trc_on & ~full;
    drop = sym_valid & trc_on & full;
  end

  always_comb begin
    fall      = trc_on_q & ~trc_on;
    fl_req    = flush | fall;
    next_buf  = acc ? {buf_q[DCT_BUF_W-DCT_SYM_W-1:0], sym} : buf_q;
    next_cnt  = cnt_q + DCT_CNT_W'(acc);
    nonempty  = (cnt_q != '0) | acc;
    full_next = (next_cnt == DCT_CNT_W'(DCT_DEPTH));
    // A buffer still full from an earlier stall re-requests until the slot frees.
    er        = full_next | (flush_pend_q & (cnt_q != '0)) | (fl_req & nonempty);
    slot_free = ~frame_valid | fr.frame_ready;
    load      = er & slot_free;

    frame_next = '{tag: TAG_DCT, cnt: next_cnt, buff: next_buf};

    buf_d        = next_buf;
    cnt_d        = next_cnt;
    flush_pend_d = flush_pend_q;
    if (load) begin
      buf_d        = '0;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
    end else if (er & fl_req) begin
      flush_pend_d = 1'b1;
    end

    // A symbol arriving while full is counted as dropped even in the cycle the slot frees.
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DCT_DROP_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (cnt_d != '0) state_d = ST_FILL;
      ST_FILL: begin
        if (load)           state_d = ST_EMPTY;
        else if (full_next) state_d = ST_FULL;
      end
      ST_FULL:  if (load) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q        <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
      trc_on_q     <= 1'b0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      trc_on_q     <= trc_on;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  final_soc_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (frame_next),
    .ready     (fr.frame_ready),
    .valid     (frame_valid),
    .data      (frame_out)
  );

  assign fr.frame_valid = frame_valid;
  assign fr.frame_data  = frame_out;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign overflow       = overflow_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_final_soc_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: queue-based reference model, per-cycle compare, directed literals.
module tb_final_soc_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        trc_on, sym_valid, flush, ovf_clr;
  logic [1:0]  sym;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  final_soc_nios2_qsys_0_oci_dct_packer_if fif();

  final_soc_nios2_qsys_0_oci_dct_packer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trc_on     (trc_on),
    .sym_valid  (sym_valid),
    .sym        (sym),
    .flush      (flush),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .fr         (fif),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: symbols held as a queue, frame slot as valid + data.
  int          sq[$];
  bit          m_fv, m_pend, m_ovf, m_trc;
  logic [35:0] m_fd;
  int          m_drop;

  function automatic logic [29:0] pack_q();
    logic [29:0] v = '0;
    foreach (sq[i]) v = (v << 2) | 30'(sq[i]);
    return v;
  endfunction

  task automatic m_reset();
    sq.delete();
    m_fv = 0; m_fd = '0; m_pend = 0; m_ovf = 0; m_drop = 0; m_trc = 0;
  endtask

  always @(posedge clk) begin
    bit acc, drp, fall, er, free;
    if (!reset_n) m_reset();
    else begin
      acc  = sym_valid && trc_on && sq.size() < 15;
      drp  = sym_valid && trc_on && sq.size() == 15;
      fall = m_trc && !trc_on;
      free = !m_fv || fif.frame_ready;
      if (acc) sq.push_back(int'(sym));
      er = (sq.size() == 15) || (sq.size() > 0 && (m_pend || flush || fall));
      if (m_fv && fif.frame_ready) m_fv = 0;
      if (er && free) begin
        m_fd = {2'b10, 4'(sq.size()), pack_q()};
        m_fv = 1;
        sq.delete();
        m_pend = 0;
      end else if (er && (flush || fall)) m_pend = 1;
      if (ovf_clr) begin m_ovf = 0; m_drop = 0; end
      else if (drp) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
      m_trc = trc_on;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (chk_en && reset_n) begin
      chk("frame_valid", 64'(fif.frame_valid), 64'(m_fv));
      if (m_fv) chk("frame_data", 64'(fif.frame_data), 64'(m_fd));
      chk("dct_count", 64'(dct_count), 64'(sq.size()));
      chk("dct_buffer", 64'(dct_buffer), 64'(pack_q()));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input int v);
    sym_valid = 1'b1;
    sym = 2'(v);
    step();
    sym_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; trc_on = 1'b1; sym_valid = 1'b0; sym = '0; flush = 1'b0;
    ovf_clr = 1'b0; fif.frame_ready = 1'b1;
    step(); step();
    chk("rst_count", 64'(dct_count), 64'd0);
    chk("rst_valid", 64'(fif.frame_valid), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    reset_n = 1'b1;
    chk_en = 1;
    step();

    // 15 accepts: full frame, oldest symbol at the top
    for (int i = 0; i < 15; i++) send(i % 4);
    chk("t1_valid", 64'(fif.frame_valid), 64'd1);
    chk("t1_data", 64'(fif.frame_data), 64'({2'b10, 4'd15, 24'h1B1B1B, 6'b000110}));
    step();
    chk("t1_count0", 64'(dct_count), 64'd0);

    // partial flush
    send(1); send(2); send(3);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t2_data", 64'(fif.frame_data), 64'({2'b10, 4'd3, 24'b0, 6'b01_10_11}));
    step();

    // accept and flush together
    for (int i = 0; i < 4; i++) send(3);
    flush = 1'b1; send(2); flush = 1'b0;
    chk("t3_cnt", 64'(fif.frame_data[33:30]), 64'd5);
    chk("t3_buf", 64'(fif.frame_data[9:0]), 64'(10'b11_11_11_11_10));
    step();

    // backpressure, fill, drops, then back-to-back drain
    fif.frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(1);
    for (int i = 0; i < 15; i++) send(3);
    for (int i = 0; i < 5; i++) send(2);
    chk("t4_held", 64'(fif.frame_data), 64'({2'b10, 4'd15, 30'h15555555}));
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_drop", 64'(drop_cnt), 64'd5);
    chk("t4_count", 64'(dct_count), 64'd15);
    fif.frame_ready = 1'b1;
    step();
    chk("t4_f2_valid", 64'(fif.frame_valid), 64'd1);
    chk("t4_f2_data", 64'(fif.frame_data), 64'({2'b10, 4'd15, 30'h3FFFFFFF}));
    step();
    chk("t4_drained", 64'(fif.frame_valid), 64'd0);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    chk("t4_clr", 64'(drop_cnt), 64'd0);

    // trace-off flush, ignored symbols, empty flush
    for (int i = 0; i < 7; i++) send(i % 4);
    trc_on = 1'b0; send(3);
    chk("t5_data", 64'(fif.frame_data), 64'({2'b10, 4'd7, 16'd0, 14'h06C6}));
    for (int i = 0; i < 3; i++) send(1);
    chk("t5_ignored", 64'(dct_count), 64'd0);
    flush = 1'b1; step(); flush = 1'b0;
    chk("t5_noframe", 64'(fif.frame_valid), 64'd0);
    trc_on = 1'b1; step();

    // async reset mid-stall
    fif.frame_ready = 1'b0;
    for (int i = 0; i < 33; i++) send($urandom_range(0, 3));
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    chk("t6_rst_valid", 64'(fif.frame_valid), 64'd0);
    chk("t6_rst_data", 64'(fif.frame_data), 64'd0);
    chk("t6_rst_count", 64'(dct_count), 64'd0);
    chk("t6_rst_buf", 64'(dct_buffer), 64'd0);
    chk("t6_rst_ovf", 64'(overflow), 64'd0);
    chk("t6_rst_drop", 64'(drop_cnt), 64'd0);
    step(); step();
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 330; i++) send($urandom_range(0, 3));
    chk("t6_sat", 64'(drop_cnt), 64'd255);
    chk("t6_ovf", 64'(overflow), 64'd1);
    ovf_clr = 1'b1; send(0); ovf_clr = 1'b0;
    chk("t6_clr_ovf", 64'(overflow), 64'd0);
    chk("t6_clr_drop", 64'(drop_cnt), 64'd0);
    fif.frame_ready = 1'b1;
    step(); step(); step();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sym_valid = ($urandom_range(0, 9) < 8);
      sym = 2'($urandom_range(0, 3));
      flush = ($urandom_range(0, 19) == 0);
      ovf_clr = ($urandom_range(0, 49) == 0);
      fif.frame_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 29) == 0) trc_on = ~trc_on;
      step();
    end
    sym_valid = 1'b0; flush = 1'b0; ovf_clr = 1'b0; trc_on = 1'b1;
    fif.frame_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
